imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Streams a program image into instruction memory through its test write port and holds the
//   PikaRISC core in reset until the image is complete and verified. It replaces the
//   bench-side $readmemh code injection with synthesizable logic fed by a byte stream.
//   It sits between a byte source (UART RX, JTAG shim or bench driver) and instrMem/PikaRISC.
// PARAMETERS
//   ADDR_WIDTH  8   log2 of instruction memory depth in 32-bit words (256 words)
// PORTS
//   clk            in   1   system clock, rising edge
//   reset          in   1   asynchronous, active-low reset
//   start          in   1   1-cycle pulse; begin a load (ignored while loading)
//   in_valid       in   1   byte-stream valid
//   in_data        in   8   byte-stream data
//   in_ready       out  1   loader can accept a byte this cycle
//   imem_wr_en     out  1   one-cycle write strobe to instrMem
//   imem_wr_addr   out  32  word index, zero-extended from ADDR_WIDTH bits
//   imem_wr_data   out  32  assembled instruction word
//   cpu_reset_n    out  1   drives PikaRISC reset; 0 holds the core
//   busy           out  1   load in progress
//   done           out  1   last load succeeded (sticky until next start or reset)
//   error          out  1   last load failed (sticky until next start or reset)
//   words_loaded   out  16  words written in the current or last load
// BEHAVIOUR
//   Reset values: all outputs 0, state IDLE. cpu_reset_n=0, so the core is held after reset.
//   Stream format, little-endian: CNT[7:0], CNT[15:8], then CNT words of 4 bytes each
//     (LSB first), then CSUM = XOR of all 4*CNT payload bytes. Header bytes are not in CSUM.
//   Byte transfer occurs on a cycle where in_valid && in_ready. in_ready is a registered
//     state decode: it is 1 in HDR0/HDR1/DATA/CSUM and 0 otherwise. in_data is ignored
//     when there is no transfer.
//   FSM states: IDLE, HDR0, HDR1, DATA, CSUM, DONE, ERR.
//     IDLE/DONE/ERR --start--> HDR0. On the same edge: clear done, error and words_loaded,
//       and set cpu_reset_n=0 and busy=1.
//     HDR0 --xfer--> HDR1. Latch CNT low byte.
//     HDR1 --xfer--> DATA if 1 <= CNT <= 2**ADDR_WIDTH; otherwise --> ERR.
//     DATA: shift bytes into a 32-bit assembler and XOR each byte into a running checksum.
//       On the 4th byte: next cycle imem_wr_en=1, addr=word index, data=assembled word.
//       Then words_loaded increments. Write latency is 1 cycle after the 4th byte transfer.
//       After word CNT-1 is transferred --> CSUM.
//     CSUM --xfer--> DONE if the byte equals the running XOR, else --> ERR.
//     DONE: done=1, busy=0, cpu_reset_n=1 (registered; core released the cycle after entry).
//     ERR: error=1, busy=0, cpu_reset_n stays 0. Words already written are not rolled back.
//   start while busy is ignored. start in the same cycle as the final CSUM transfer is
//     ignored; the FSM completes to DONE or ERR.
//   Word index never wraps: CNT is range-checked in HDR1. CNT == 2**ADDR_WIDTH writes
//     index 0..DEPTH-1.
//   Stalls: in_valid may drop at any byte. No state advances without a transfer, and
//     there is no timeout.
//   reset asserted mid-load: return to IDLE immediately, hold the core, clear all flags.
//     Partial imem contents are left as-is.
//   imem_wr_en is never asserted outside DATA plus the one following cycle.
// STRUCTURE
//   Shared package pika_pkg: state encoding enum, header length constant (2), checksum width.
//   One sub-module, loader_word_asm: 4-byte shift assembler with byte counter and word_ready
//     pulse. The FSM, checksum, counters and flags stay in imem_loader.
// TESTING
//   Happy path: CNT=2, words 0x00500093, 0x00A00113, correct CSUM ->
//     writes (0,0x00500093), (1,0x00A00113), done=1, cpu_reset_n=1, words_loaded=2.
//   Bad checksum: same stream with CSUM^0x01 -> both words written, error=1, done=0,
//     cpu_reset_n stays 0.
//   Header bounds: CNT=0 -> ERR after HDR1 with no writes.
//     CNT=257 with ADDR_WIDTH=8 -> ERR. CNT=256 -> 256 writes, last at addr 0xFF.
//   Backpressure/stall: random 0-5 cycle gaps in in_valid -> identical writes.
//     in_data toggling while in_valid=0 has no effect.
//   Reset mid-load: assert reset after 5 payload bytes -> all outputs return to reset values.
//     A new start then completes a fresh load correctly.
//   Re-load: start from DONE -> cpu_reset_n falls the next cycle, done clears.
//     A second image overwrites from addr 0. start while busy is ignored.

Source files
------------

// File: rtl/pika_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and stream framing constants.
package pika_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR0 = 3'd1,
    ST_HDR1 = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_t;

  localparam int HDR_LEN = 2;
  localparam int CSUM_W  = 8;

endpackage

// File: rtl/loader_word_asm.sv
// Packs a little-endian byte stream into 32-bit words; o_word_ready pulses the cycle after
// the 4th byte of each word is accepted.
module loader_word_asm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_byte_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_ready,
  output logic        o_last_byte
);

  logic [1:0]  r_byte_cnt;
  logic [31:0] r_word;
  logic        r_word_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt   <= 2'd0;
      r_word       <= 32'd0;
      r_word_ready <= 1'b0;
    end else begin
      r_word_ready <= 1'b0;
      if (i_clr) begin
        r_byte_cnt <= 2'd0;
      end else if (i_byte_en) begin
        // shift right so the first (least significant) byte ends up in [7:0]
        r_word       <= {i_byte, r_word[31:8]};
        r_byte_cnt   <= r_byte_cnt + 2'd1;
        r_word_ready <= (r_byte_cnt == 2'd3);
      end
    end
  end

  assign o_word       = r_word;
  assign o_word_ready = r_word_ready;
  assign o_last_byte  = (r_byte_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams a checksummed program image into instruction memory and holds the core in reset
// until the image has been fully written and verified.
//
// state | meaning
// IDLE  | after reset, core held, waiting for start
// HDR0  | waiting for word count low byte
// HDR1  | waiting for word count high byte, range check
// DATA  | receiving payload words, writing imem
// CSUM  | waiting for XOR checksum byte
// DONE  | image verified, core released
// ERR   | bad count or checksum, core held
module imem_loader
  import pika_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_wr_en,
  output logic [31:0] imem_wr_addr,
  output logic [31:0] imem_wr_data,
  output logic        cpu_reset_n,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam logic [31:0] DEPTH = 32'd1 << ADDR_WIDTH;

  state_t              r_state;
  logic                r_in_ready;
  logic                r_cpu_reset_n;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic [15:0]         r_words_loaded;
  logic [15:0]         r_words_left;
  logic [7:0]          r_cnt_lo;
  logic [CSUM_W-1:0]   r_csum;

  logic                w_xfer;
  logic                w_start_ok;
  logic [15:0]         w_cnt;
  logic                w_cnt_ok;
  logic                w_word_ready;
  logic                w_last_byte;
  logic [31:0]         w_word;

  assign w_xfer     = in_valid && r_in_ready;
  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
  assign w_cnt      = {in_data, r_cnt_lo};
  assign w_cnt_ok   = (w_cnt != 16'd0) && ({16'd0, w_cnt} <= DEPTH);

  loader_word_asm u_word_asm (
    .clk          (clk),
    .rst_n        (reset),
    .i_clr        (w_start_ok),
    .i_byte_en    (w_xfer && (r_state == ST_DATA)),
    .i_byte       (in_data),
    .o_word       (w_word),
    .o_word_ready (w_word_ready),
    .o_last_byte  (w_last_byte)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_in_ready     <= 1'b0;
      r_cpu_reset_n  <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_words_loaded <= 16'd0;
      r_words_left   <= 16'd0;
      r_cnt_lo       <= 8'd0;
      r_csum         <= '0;
    end else begin
      // the write strobe for a word lands one cycle after its last byte
      if (w_word_ready) r_words_loaded <= r_words_loaded + 16'd1;

      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (w_start_ok) begin
            r_state        <= ST_HDR0;
            r_in_ready     <= 1'b1;
            r_busy         <= 1'b1;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_cpu_reset_n  <= 1'b0;
            r_words_loaded <= 16'd0;
            r_csum         <= '0;
          end
        end
        ST_HDR0: begin
          if (w_xfer) begin
            r_cnt_lo <= in_data;
            r_state  <= ST_HDR1;
          end
        end
        ST_HDR1: begin
          if (w_xfer) begin
            if (w_cnt_ok) begin
              r_words_left <= w_cnt;
              r_state      <= ST_DATA;
            end else begin
              r_state    <= ST_ERR;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_error    <= 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (w_xfer) begin
            r_csum <= r_csum ^ in_data;
            if (w_last_byte) begin
              r_words_left <= r_words_left - 16'd1;
              if (r_words_left == 16'd1) r_state <= ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (w_xfer) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            if (in_data == r_csum) begin
              r_state       <= ST_DONE;
              r_done        <= 1'b1;
              r_cpu_reset_n <= 1'b1;
            end else begin
              r_state <= ST_ERR;
              r_error <= 1'b1;
            end
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign imem_wr_en   = w_word_ready;
  assign imem_wr_addr = {{(32-ADDR_WIDTH){1'b0}}, r_words_loaded[ADDR_WIDTH-1:0]};
  assign imem_wr_data = w_word;
  assign cpu_reset_n  = r_cpu_reset_n;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: happy path, reload, bad checksum, count bounds, stalls, reset mid-load.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_wr_en;
  logic [31:0] imem_wr_addr;
  logic [31:0] imem_wr_data;
  logic        cpu_reset_n;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int checks = 0;
  int errors = 0;

  logic [7:0]  img[$];
  logic [31:0] words[$];
  logic [63:0] exp_w[$];
  logic [63:0] wq[$];

  imem_loader #(.ADDR_WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_wr_en   (imem_wr_en),
    .imem_wr_addr (imem_wr_addr),
    .imem_wr_data (imem_wr_data),
    .cpu_reset_n  (cpu_reset_n),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset && imem_wr_en) wq.push_back({imem_wr_addr, imem_wr_data});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic build(input logic [15:0] cnt, input logic [7:0] csum_flip);
    logic [7:0] cs;
    cs = 8'h00;
    img = {};
    exp_w = {};
    img.push_back(cnt[7:0]);
    img.push_back(cnt[15:8]);
    for (int i = 0; i < words.size(); i++) begin
      logic [31:0] w;
      w = words[i];
      for (int b = 0; b < 4; b++) begin
        img.push_back(w[8*b +: 8]);
        cs = cs ^ w[8*b +: 8];
      end
      exp_w.push_back({32'(i), w});
    end
    img.push_back(cs ^ csum_flip);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_range(input int first, input int last, input int max_gap);
    for (int i = first; i <= last; i++) begin
      int gap;
      int n;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = img[i];
      n = 0;
      while (!in_ready && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      check("in_ready_wait", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
  endtask

  task automatic verify_writes(input string tag);
    check({tag, "_nwrites"}, 32'(wq.size()), 32'(exp_w.size()));
    for (int i = 0; i < wq.size() && i < exp_w.size(); i++) begin
      check({tag, "_addr"}, wq[i][63:32], exp_w[i][63:32]);
      check({tag, "_data"}, wq[i][31:0], exp_w[i][31:0]);
    end
  endtask

  task automatic check_flags(input string tag, input logic d, input logic e, input logic c,
                             input logic b, input logic [15:0] wl);
    check({tag, "_done"}, {31'd0, done}, {31'd0, d});
    check({tag, "_error"}, {31'd0, error}, {31'd0, e});
    check({tag, "_cpu_reset_n"}, {31'd0, cpu_reset_n}, {31'd0, c});
    check({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
    check({tag, "_words_loaded"}, {16'd0, words_loaded}, {16'd0, wl});
  endtask

  task automatic check_reset_vals(input string tag);
    check_flags(tag, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_wr_en"}, {31'd0, imem_wr_en}, 32'd0);
    check({tag, "_wr_addr"}, imem_wr_addr, 32'd0);
    check({tag, "_wr_data"}, imem_wr_data, 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset = 1'b1;
    @(posedge clk); #1;

    // happy path, checksum 0x71
    words = {32'h00500093, 32'h00A00113};
    build(16'd2, 8'h00);
    check("csum_model", 32'(img[10]), 32'h71);
    wq = {};
    pulse_start();
    check_flags("start1", 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
    check("start1_in_ready", {31'd0, in_ready}, 32'd1);
    send_range(0, 5, 0);
    check("lat_wr_en", {31'd0, imem_wr_en}, 32'd1);
    check("lat_wr_addr", imem_wr_addr, 32'd0);
    check("lat_wr_data", imem_wr_data, 32'h00500093);
    send_range(6, img.size() - 1, 0);
    repeat (2) @(posedge clk);
    #1;
    verify_writes("happy");
    check_flags("happy", 1'b1, 1'b0, 1'b1, 1'b0, 16'd2);
    check("happy_in_ready", {31'd0, in_ready}, 32'd0);

    // reload from DONE, with an ignored start while busy
    words = {32'hDEADBEEF, 32'h12345678};
    build(16'd2, 8'h00);
    check("csum_model2", 32'(img[10]), 32'h2A);
    wq = {};
    pulse_start();
    check_flags("reload", 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
    send_range(0, 5, 0);
    @(posedge clk); #1;
    pulse_start();
    check_flags("busy_start", 1'b0, 1'b0, 1'b0, 1'b1, 16'd1);
    send_range(6, img.size() - 1, 0);
    repeat (2) @(posedge clk);
    #1;
    verify_writes("reload");
    check_flags("reload_end", 1'b1, 1'b0, 1'b1, 1'b0, 16'd2);

    // bad checksum
    words = {32'h00500093, 32'h00A00113};
    build(16'd2, 8'h01);
    wq = {};
    pulse_start();
    send_range(0, img.size() - 1, 0);
    repeat (2) @(posedge clk);
    #1;
    verify_writes("badcs");
    check_flags("badcs", 1'b0, 1'b1, 1'b0, 1'b0, 16'd2);

    // CNT = 0
    words = {};
    build(16'd0, 8'h00);
    wq = {};
    pulse_start();
    send_range(0, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    verify_writes("cnt0");
    check_flags("cnt0", 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    check("cnt0_in_ready", {31'd0, in_ready}, 32'd0);

    // CNT = 257
    build(16'd257, 8'h00);
    wq = {};
    pulse_start();
    send_range(0, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    check("cnt257_nwrites", 32'(wq.size()), 32'd0);
    check_flags("cnt257", 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);

    // CNT = 256, full depth
    words = {};
    for (int i = 0; i < 256; i++) words.push_back({8'(i + 3), ~8'(i), 8'(i) ^ 8'h5A, 8'(i)});
    build(16'd256, 8'h00);
    wq = {};
    pulse_start();
    send_range(0, img.size() - 1, 0);
    repeat (2) @(posedge clk);
    #1;
    verify_writes("full");
    check("full_last_addr", (wq.size() > 0) ? wq[wq.size()-1][63:32] : 32'hFFFF_FFFF, 32'h0000_00FF);
    check_flags("full", 1'b1, 1'b0, 1'b1, 1'b0, 16'd256);

    // stalls with in_data noise during gaps
    words = {32'h00500093, 32'h00A00113};
    build(16'd2, 8'h00);
    wq = {};
    pulse_start();
    send_range(0, img.size() - 1, 5);
    repeat (2) @(posedge clk);
    #1;
    verify_writes("stall");
    check_flags("stall", 1'b1, 1'b0, 1'b1, 1'b0, 16'd2);

    // reset after 5 payload bytes, then a fresh load
    wq = {};
    pulse_start();
    send_range(0, 6, 0);
    reset = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("midrst_rel");
    wq = {};
    pulse_start();
    send_range(0, img.size() - 1, 2);
    repeat (2) @(posedge clk);
    #1;
    verify_writes("postrst");
    check_flags("postrst", 1'b1, 1'b0, 1'b1, 1'b0, 16'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
